// File: rtl/reg_bank_sb.sv
// reg_bank_sb: sixteen-entry register bank with a per-register busy scoreboard.
// Sits between decode and the ALU operand inputs. Writes are steered by a
// 1-to-16 demux, the two read ports are independent 16-to-1 muxes, and the
// read operands are registered with a write-first bypass so that a same-edge
// write is visible without a combinational path from w_data to rd_data_*.
// The scoreboard marks registers with an outstanding multi-cycle result and
// refuses a second reservation until the pending write lands.

module reg_bank_sb #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_en,
  input  logic [3:0]           rd_addr_a,
  input  logic [3:0]           rd_addr_b,
  output logic [DATA_BITS-1:0] rd_data_a,
  output logic [DATA_BITS-1:0] rd_data_b,
  output logic                 rd_valid,
  output logic                 busy_a,
  output logic                 busy_b,
  input  logic                 reserve_en,
  input  logic [3:0]           reserve_addr,
  output logic                 reserve_ready,
  input  logic                 we,
  input  logic [3:0]           w_addr,
  input  logic [DATA_BITS-1:0] w_data,
  output logic [15:0]          busy_vec
);

  // Per-register scoreboard states (one flop per register).
  localparam logic [0:0] SB_IDLE = 1'b0;
  localparam logic [0:0] SB_BUSY = 1'b1;

  logic [DATA_BITS-1:0] regs [16];
  logic [15:0]          busy;
  logic [15:0]          busy_nxt;
  logic [15:0]          wr_sel;
  logic [15:0]          res_sel;
  logic [DATA_BITS-1:0] mux_a;
  logic [DATA_BITS-1:0] mux_b;
  logic                 hit_a;
  logic                 hit_b;
  logic                 hit_res;
  logic                 res_accept;

  // Address-match terms shared by the bypass, busy and handshake logic.
  assign hit_a   = we && (w_addr == rd_addr_a);
  assign hit_b   = we && (w_addr == rd_addr_b);
  assign hit_res = we && (w_addr == reserve_addr);

  // A same-cycle write retires the pending result, so it clears the hazard
  // and frees the register for a new reservation immediately.
  assign busy_a        = busy[rd_addr_a] & ~hit_a;
  assign busy_b        = busy[rd_addr_b] & ~hit_b;
  assign reserve_ready = ~busy[reserve_addr] | hit_res;
  assign res_accept    = reserve_en & reserve_ready;
  assign busy_vec      = busy;

  // Write demux: one-hot register select for the write port.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < 16; i++) begin
      if (we && (w_addr == 4'(i))) wr_sel[i] = 1'b1;
    end
  end

  // Reservation demux: one-hot select, only when the handshake accepts.
  always_comb begin
    res_sel = '0;
    for (int i = 0; i < 16; i++) begin
      if (res_accept && (reserve_addr == 4'(i))) res_sel[i] = 1'b1;
    end
  end

  // Read mux for port a.
  always_comb begin
    mux_a = '0;
    for (int i = 0; i < 16; i++) begin
      if (rd_addr_a == 4'(i)) mux_a = regs[i];
    end
  end

  // Read mux for port b.
  always_comb begin
    mux_b = '0;
    for (int i = 0; i < 16; i++) begin
      if (rd_addr_b == 4'(i)) mux_b = regs[i];
    end
  end

  // Scoreboard next state; a reserve to the same register as a write wins.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < 16; i++) begin
      if (busy[i] == SB_IDLE) begin
        busy_nxt[i] = res_sel[i] ? SB_BUSY : SB_IDLE;
      end else begin
        busy_nxt[i] = (wr_sel[i] && !res_sel[i]) ? SB_IDLE : SB_BUSY;
      end
    end
  end

  // Scoreboard flops; reset discards any outstanding reservation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  // Register storage, written through the demux select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wr_sel[i]) regs[i] <= w_data;
      end
    end
  end

  // Registered read operands with write-first bypass; hold when rd_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= hit_a ? w_data : mux_a;
        rd_data_b <= hit_b ? w_data : mux_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb_reg_bank_sb: directed plus short random test of reg_bank_sb.
// Read results are predicted when rd_en is driven, queued, and compared when
// the DUT raises rd_valid. Combinational busy/ready outputs and busy_vec are
// compared against a small behavioural model every cycle.

module tb_reg_bank_sb;

  localparam int DATA_BITS = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 rd_en = 1'b0;
  logic [3:0]           rd_addr_a = '0;
  logic [3:0]           rd_addr_b = '0;
  logic [DATA_BITS-1:0] rd_data_a;
  logic [DATA_BITS-1:0] rd_data_b;
  logic                 rd_valid;
  logic                 busy_a;
  logic                 busy_b;
  logic                 reserve_en = 1'b0;
  logic [3:0]           reserve_addr = '0;
  logic                 reserve_ready;
  logic                 we = 1'b0;
  logic [3:0]           w_addr = '0;
  logic [DATA_BITS-1:0] w_data = '0;
  logic [15:0]          busy_vec;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [DATA_BITS-1:0]   m_regs [16];
  logic [15:0]            m_busy;
  logic [DATA_BITS-1:0]   m_data_a;
  logic [DATA_BITS-1:0]   m_data_b;
  logic                   m_valid;
  logic [2*DATA_BITS-1:0] exp_q [$];

  reg_bank_sb #(.DATA_BITS(DATA_BITS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_en         (rd_en),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .rd_valid      (rd_valid),
    .busy_a        (busy_a),
    .busy_b        (busy_b),
    .reserve_en    (reserve_en),
    .reserve_addr  (reserve_addr),
    .reserve_ready (reserve_ready),
    .we            (we),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .busy_vec      (busy_vec)
  );

  always #5 clk = ~clk;

  // One comparison; counts it and reports any failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_busy   = '0;
    m_data_a = '0;
    m_data_b = '0;
    m_valid  = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic ren, input logic [3:0] ra, input logic [3:0] rb,
                               input logic ren_res, input logic [3:0] raddr,
                               input logic wen, input logic [3:0] wa,
                               input logic [DATA_BITS-1:0] wd);
    rd_en        = ren;
    rd_addr_a    = ra;
    rd_addr_b    = rb;
    reserve_en   = ren_res;
    reserve_addr = raddr;
    we           = wen;
    w_addr       = wa;
    w_data       = wd;
    #1;
  endtask

  // Check combinational outputs, predict, clock one edge, check registered outputs.
  task automatic edgeStep();
    logic                 hit_a;
    logic                 hit_b;
    logic                 rdy;
    logic [DATA_BITS-1:0] ea;
    logic [DATA_BITS-1:0] eb;
    logic [2*DATA_BITS-1:0] got;
    hit_a = we && (w_addr == rd_addr_a);
    hit_b = we && (w_addr == rd_addr_b);
    rdy   = !m_busy[reserve_addr] || (we && (w_addr == reserve_addr));
    checkOutput("busy_a", busy_a, m_busy[rd_addr_a] && !hit_a);
    checkOutput("busy_b", busy_b, m_busy[rd_addr_b] && !hit_b);
    checkOutput("reserve_ready", reserve_ready, rdy);
    if (rd_en) begin
      ea = hit_a ? w_data : m_regs[rd_addr_a];
      eb = hit_b ? w_data : m_regs[rd_addr_b];
      exp_q.push_back({ea, eb});
      m_data_a = ea;
      m_data_b = eb;
    end
    if (we) begin
      m_regs[w_addr] = w_data;
      m_busy[w_addr] = 1'b0;
    end
    if (reserve_en && rdy) m_busy[reserve_addr] = 1'b1;
    m_valid = rd_en;
    @(posedge clk);
    #1;
    checkOutput("rd_valid", rd_valid, m_valid);
    checkOutput("busy_vec", busy_vec, m_busy);
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("read_unexpected", 32'd1, 32'd0);
      end else begin
        got = exp_q.pop_front();
        checkOutput("sb_rd_data_a", rd_data_a, got[2*DATA_BITS-1:DATA_BITS]);
        checkOutput("sb_rd_data_b", rd_data_b, got[DATA_BITS-1:0]);
      end
    end else begin
      checkOutput("hold_rd_data_a", rd_data_a, m_data_a);
      checkOutput("hold_rd_data_b", rd_data_b, m_data_b);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    modelReset();
    #22;
    checkOutput("reset_busy_vec", busy_vec, 16'h0000);
    checkOutput("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_rd_data_a", rd_data_a, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Read r0 and r15 straight out of reset.
    applyStimulus(1'b1, 4'd0, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    edgeStep();
    checkOutput("r0_read", rd_data_a, 8'h00);
    checkOutput("r15_read", rd_data_b, 8'h00);
    checkOutput("first_rd_valid", rd_valid, 1'b1);
    checkOutput("first_busy_vec", busy_vec, 16'h0000);

    // Write r5 then read it on both ports; then hold.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 8'hA5);
    edgeStep();
    applyStimulus(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    edgeStep();
    checkOutput("r5_port_a", rd_data_a, 8'hA5);
    checkOutput("r5_port_b", rd_data_b, 8'hA5);
    idle();
    edgeStep();
    checkOutput("hold_a_A5", rd_data_a, 8'hA5);
    checkOutput("hold_valid_low", rd_valid, 1'b0);

    // Same-edge write and read of r3 on port a (bypass); port b reads r0.
    applyStimulus(1'b1, 4'd3, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 8'h3C);
    edgeStep();
    checkOutput("bypass_a", rd_data_a, 8'h3C);
    checkOutput("bypass_b_other", rd_data_b, 8'h00);

    // Reserve r7, observe busy, refuse re-reserve, then clear by write.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 8'h00);
    checkOutput("r7_ready_idle", reserve_ready, 1'b1);
    edgeStep();
    checkOutput("r7_reserved", busy_vec, 16'h0080);
    applyStimulus(1'b0, 4'd7, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 8'h00);
    checkOutput("r7_busy_a", busy_a, 1'b1);
    checkOutput("r7_reready", reserve_ready, 1'b0);
    edgeStep();
    checkOutput("r7_unchanged", busy_vec, 16'h0080);
    applyStimulus(1'b0, 4'd7, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 8'h42);
    checkOutput("r7_write_clears_busy_a", busy_a, 1'b0);
    checkOutput("r7_busy_vec_before_edge", busy_vec, 16'h0080);
    edgeStep();
    checkOutput("r7_cleared", busy_vec, 16'h0000);
    applyStimulus(1'b1, 4'd7, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    edgeStep();
    checkOutput("r7_read", rd_data_a, 8'h42);
    checkOutput("r3_read", rd_data_b, 8'h3C);

    // Busy r9 written and re-reserved at the same edge: reservation wins.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 1'b0, 4'd0, 8'h00);
    edgeStep();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 1'b1, 4'd9, 8'h11);
    checkOutput("r9_ready_on_write", reserve_ready, 1'b1);
    edgeStep();
    checkOutput("r9_still_busy", busy_vec, 16'h0200);
    applyStimulus(1'b1, 4'd9, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    edgeStep();
    checkOutput("r9_data", rd_data_a, 8'h11);

    // Write r15 and reserve r10 together; both take effect.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd10, 1'b1, 4'd15, 8'hF0);
    edgeStep();
    checkOutput("r10_r9_busy", busy_vec, 16'h0600);
    applyStimulus(1'b1, 4'd15, 4'd10, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    checkOutput("r10_busy_b", busy_b, 1'b1);
    edgeStep();
    checkOutput("r15_data", rd_data_a, 8'hF0);

    // Asynchronous reset between edges with r2 written and busy.
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 1'b1, 4'd2, 8'hFF);
    edgeStep();
    applyStimulus(1'b1, 4'd2, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    edgeStep();
    checkOutput("r2_before_reset", rd_data_a, 8'hFF);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_busy_vec", busy_vec, 16'h0000);
    checkOutput("async_rd_data_a", rd_data_a, 8'h00);
    checkOutput("async_rd_data_b", rd_data_b, 8'h00);
    checkOutput("async_rd_valid", rd_valid, 1'b0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0, 8'h00);
    edgeStep();
    checkOutput("r2_after_reset", rd_data_a, 8'h00);

    // Short random run against the model.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      edgeStep();
    end

    idle();
    edgeStep();
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
